// File: rtl/mem_writeback.sv
// mem_writeback: memory-access / write-back stage of a small processor.
// Accepts an instruction when the processor FSM is in MEMORY_ACCESS (4).
// Loads (LW) issue a data-memory read and wait for dmem_ready; other
// result-producing instructions go straight to the register-file write.
// Instructions that produce no result retire without side effects.
// Optional feature macro: WB_TIMEOUT_EN enables a load-timeout watchdog
// that aborts a load after MEM_TIMEOUT cycles and sets the sticky
// mem_error flag. Without it, MEM_WAIT waits indefinitely and mem_error
// is tied to 0.
module mem_writeback #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] current_state,
    input  logic [5:0] operation_code,
    input  logic [7:0] execution_result,
    input  logic       execution_result_valid,
    input  logic [4:0] dest_reg,
    output logic       dmem_req,
    output logic [7:0] dmem_addr,
    input  logic       dmem_ready,
    input  logic [7:0] dmem_rdata,
    output logic       rf_we,
    output logic [4:0] rf_waddr,
    output logic [7:0] rf_wdata,
    output logic       wb_done,
    output logic [7:0] last_result,
    output logic       mem_error
);

    localparam logic [2:0] MEMORY_ACCESS = 3'd4;
    localparam logic [5:0] OP_LW         = 6'b100011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       rst_sync_q;
    logic       dmem_req_q, dmem_req_d;
    logic [7:0] dmem_addr_q, dmem_addr_d;
    logic       rf_we_q, rf_we_d;
    logic [4:0] rf_waddr_q, rf_waddr_d;
    logic [7:0] rf_wdata_q, rf_wdata_d;
    logic       wb_done_q, wb_done_d;
    logic [7:0] last_result_q, last_result_d;

`ifdef WB_TIMEOUT_EN
    // Last count value before the watchdog fires (counter starts at 0).
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 32'd1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       mem_error_q, mem_error_d;
`endif

    // Reset release synchronizer: the core stays in reset for one edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    // Next-state and registered-output logic of the write-back FSM.
    always_comb begin
        state_d       = state_q;
        dmem_req_d    = dmem_req_q;
        dmem_addr_d   = dmem_addr_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        wb_done_d     = 1'b0;
        last_result_d = last_result_q;
`ifdef WB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        mem_error_d   = mem_error_q;
`endif
        if (!rst_sync_q) begin
            // Synchronous tail of reset: hold every register at its reset value.
            state_d       = ST_IDLE;
            dmem_req_d    = 1'b0;
            dmem_addr_d   = 8'h00;
            rf_waddr_d    = 5'd0;
            rf_wdata_d    = 8'h00;
            last_result_d = 8'h00;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_d     = 8'h00;
            mem_error_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (current_state == MEMORY_ACCESS) begin
                        if (!execution_result_valid) begin
                            state_d = ST_DONE;
                        end else if (operation_code == OP_LW) begin
                            rf_waddr_d  = dest_reg;
                            dmem_addr_d = execution_result;
                            dmem_req_d  = 1'b1;
                            state_d     = ST_MEM_WAIT;
`ifdef WB_TIMEOUT_EN
                            tmo_cnt_d   = 8'h00;
`endif
                        end else begin
                            rf_waddr_d = dest_reg;
                            rf_wdata_d = execution_result;
                            state_d    = ST_WRITE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        rf_wdata_d = dmem_rdata;
                        dmem_req_d = 1'b0;
                        state_d    = ST_WRITE;
                    end else begin
`ifdef WB_TIMEOUT_EN
                        if (tmo_cnt_q >= TMO_LAST) begin
                            dmem_req_d  = 1'b0;
                            mem_error_d = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + 8'd1;
                        end
`else
                        state_d = ST_MEM_WAIT;
`endif
                    end
                end
                ST_WRITE: begin
                    // Register 0 is hard-wired: no write, last_result untouched.
                    if (rf_waddr_q != 5'd0) begin
                        rf_we_d       = 1'b1;
                        last_result_d = rf_wdata_q;
                    end else begin
                        rf_we_d = 1'b0;
                    end
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    wb_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; rst_n forces everything idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dmem_req_q    <= 1'b0;
            dmem_addr_q   <= 8'h00;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 5'd0;
            rf_wdata_q    <= 8'h00;
            wb_done_q     <= 1'b0;
            last_result_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            dmem_req_q    <= dmem_req_d;
            dmem_addr_q   <= dmem_addr_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            wb_done_q     <= wb_done_d;
            last_result_q <= last_result_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q   <= 8'h00;
            mem_error_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;
`else
    assign mem_error = 1'b0;
`endif

    assign dmem_req    = dmem_req_q;
    assign dmem_addr   = dmem_addr_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign wb_done     = wb_done_q;
    assign last_result = last_result_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: each issued instruction pushes its
// expected retirement record; the record is popped and compared against
// what the monitor observed once wb_done has been seen.
module tb_mem_writeback;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] current_state = 3'd0;
    logic [5:0] operation_code = 6'd0;
    logic [7:0] execution_result = 8'h00;
    logic       execution_result_valid = 1'b0;
    logic [4:0] dest_reg = 5'd0;
    logic       dmem_req;
    logic [7:0] dmem_addr;
    logic       dmem_ready = 1'b0;
    logic [7:0] dmem_rdata = 8'h00;
    logic       rf_we;
    logic [4:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       wb_done;
    logic [7:0] last_result;
    logic       mem_error;

    mem_writeback #(.MEM_TIMEOUT(TMO)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .current_state          (current_state),
        .operation_code         (operation_code),
        .execution_result       (execution_result),
        .execution_result_valid (execution_result_valid),
        .dest_reg               (dest_reg),
        .dmem_req               (dmem_req),
        .dmem_addr              (dmem_addr),
        .dmem_ready             (dmem_ready),
        .dmem_rdata             (dmem_rdata),
        .rf_we                  (rf_we),
        .rf_waddr               (rf_waddr),
        .rf_wdata               (rf_wdata),
        .wb_done                (wb_done),
        .last_result            (last_result),
        .mem_error              (mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        int         lat;
        int         req;
        logic [7:0] raddr;
        logic [7:0] last;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] model_last = 8'h00;
    logic       model_err  = 1'b0;

    // Monitor: samples DUT outputs 1 time unit after every rising edge.
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         we_cnt = 0;
    int         req_cnt = 0;
    logic [4:0] cap_addr = 5'd0;
    logic [7:0] cap_data = 8'h00;
    logic [7:0] req_addr = 8'h00;

    always @(posedge clk) begin
        #1;
        cyc <= cyc + 1;
        if (wb_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc + 1;
        end
        if (rf_we) begin
            we_cnt   <= we_cnt + 1;
            cap_addr <= rf_waddr;
            cap_data <= rf_wdata;
        end
        if (dmem_req) begin
            req_cnt  <= req_cnt + 1;
            req_addr <= dmem_addr;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one instruction, push its expectation, then pop and compare at retirement.
    // delay = cycles until dmem_ready for a load; 0 = never answer.
    task automatic issue(input logic [5:0] op, input logic [7:0] res, input logic valid,
                         input logic [4:0] dest, input logic [7:0] rdata, input int delay);
        exp_t e;
        exp_t g;
        bit   is_load;
        int   d0, w0, r0, acc;
        is_load = valid && (op == 6'b100011);
        e.addr  = dest;
        e.raddr = res;
        e.data  = 8'h00;
        e.err   = model_err;
        if (!valid) begin
            e.we = 1'b0; e.lat = 1; e.req = 0;
        end else if (is_load && delay == 0) begin
            e.we = 1'b0; e.err = 1'b1; e.lat = 1 + TMO; e.req = TMO;
        end else if (is_load) begin
            e.we = (dest != 5'd0); e.data = rdata; e.lat = 2 + delay; e.req = delay;
        end else begin
            e.we = (dest != 5'd0); e.data = res; e.lat = 2; e.req = 0;
        end
        if (e.we) model_last = e.data;
        model_err = e.err;
        e.last = model_last;
        sb_q.push_back(e);

        @(negedge clk);
        d0 = done_cnt; w0 = we_cnt; r0 = req_cnt;
        current_state = 3'd4; operation_code = op; execution_result = res;
        execution_result_valid = valid; dest_reg = dest;
        @(negedge clk);
        acc = cyc;
        // Perturb inputs while busy; they must have no effect.
        current_state = 3'd1; operation_code = 6'b100011; execution_result = ~res;
        execution_result_valid = 1'b1; dest_reg = ~dest;
        if (is_load && delay > 0) begin
            repeat (delay - 1) @(negedge clk);
            dmem_ready = 1'b1; dmem_rdata = rdata;
            @(negedge clk);
            dmem_ready = 1'b0; dmem_rdata = 8'hEE;
        end else if (!is_load) begin
            dmem_ready = 1'b1; dmem_rdata = 8'hEE;
            @(negedge clk);
            dmem_ready = 1'b0;
        end
        for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge clk);
        @(negedge clk);
        g = sb_q.pop_front();
        check_val("wb_done_pulses", done_cnt - d0, 1);
        check_val("latency", done_cyc - acc, g.lat);
        check_val("rf_we_cycles", we_cnt - w0, {31'd0, g.we});
        if (g.we) begin
            check_val("rf_waddr", {27'd0, cap_addr}, {27'd0, g.addr});
            check_val("rf_wdata", {24'd0, cap_data}, {24'd0, g.data});
        end
        check_val("dmem_req_cycles", req_cnt - r0, g.req);
        if (g.req > 0) check_val("dmem_addr", {24'd0, req_addr}, {24'd0, g.raddr});
        check_val("last_result", {24'd0, last_result}, {24'd0, g.last});
        check_val("mem_error", {31'd0, mem_error}, {31'd0, g.err});
    endtask

    initial begin
        int d0, w0;
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check_val("rst_wb_done", {31'd0, wb_done}, 32'd0);
        check_val("rst_last", {24'd0, last_result}, 32'd0);
        check_val("rst_mem_error", {31'd0, mem_error}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Not in MEMORY_ACCESS: must be ignored
        d0 = done_cnt; w0 = we_cnt;
        current_state = 3'd3; operation_code = 6'b001001; execution_result = 8'h5A;
        execution_result_valid = 1'b1; dest_reg = 5'd2;
        repeat (4) @(negedge clk);
        current_state = 3'd0;
        repeat (2) @(negedge clk);
        check_val("idle_ignore_done", done_cnt - d0, 0);
        check_val("idle_ignore_we", we_cnt - w0, 0);

        issue(6'b001001, 8'h2A, 1'b1, 5'd3, 8'h00, 0);   // ADDIU
        issue(6'b100011, 8'h10, 1'b1, 5'd7, 8'h55, 3);   // LW, ready after 3
        issue(6'b000100, 8'h99, 1'b0, 5'd4, 8'h00, 0);   // BEQ
        issue(6'b000000, 8'hFF, 1'b1, 5'd0, 8'h00, 0);   // ADDU to r0
        issue(6'b100011, 8'hA0, 1'b1, 5'd31, 8'h3C, 1);  // LW, immediate ready
        issue(6'b100011, 8'h44, 1'b1, 5'd0, 8'h11, 2);   // LW to r0
        for (int k = 0; k < 4; k++) begin
            issue(6'b001000, 8'($urandom), 1'b1, 5'($urandom_range(1, 31)), 8'h00, 0);
        end
`ifdef WB_TIMEOUT_EN
        issue(6'b100011, 8'h20, 1'b1, 5'd6, 8'h00, 0);   // LW timeout
        issue(6'b001001, 8'h0F, 1'b1, 5'd8, 8'h00, 0);   // error stays sticky
`endif

        // Reset during MEM_WAIT
        @(negedge clk);
        current_state = 3'd4; operation_code = 6'b100011; execution_result = 8'h30;
        execution_result_valid = 1'b1; dest_reg = 5'd9;
        @(negedge clk);
        current_state = 3'd0;
        repeat (2) @(negedge clk);
        check_val("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        w0 = we_cnt;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        check_val("mid_rst_addr", {24'd0, dmem_addr}, 32'd0);
        check_val("mid_rst_last", {24'd0, last_result}, 32'd0);
        check_val("mid_rst_err", {31'd0, mem_error}, 32'd0);
        model_last = 8'h00;
        model_err  = 1'b0;
        @(negedge clk);
        check_val("rst_no_we", we_cnt - w0, 0);
        // Release with an instruction already presented: first edge must not accept it.
        rst_n = 1'b1;
        current_state = 3'd4; operation_code = 6'b001001; execution_result = 8'h77;
        execution_result_valid = 1'b1; dest_reg = 5'd5;
        @(posedge clk);
        issue(6'b001001, 8'h77, 1'b1, 5'd5, 8'h00, 0);
        issue(6'b001001, 8'h81, 1'b1, 5'd12, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, maximum wait cycles for dmem_ready before abort (legal 1..255).
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: current_state  in  3  processor FSM state; 4 = MEMORY_ACCESS.
REQ-005 Port: operation_code  in  6  opcode of the current instruction.
REQ-006 Port: execution_result  in  8  ALU result from execute; used as load address or write data.
REQ-007 Port: execution_result_valid  in  1  1 = instruction produces a register result.
REQ-008 Port: dest_reg  in  5  destination register index.
REQ-009 Port: dmem_req  out  1  data-memory read request, held high until accepted.
REQ-010 Port: dmem_addr  out  8  data-memory read address.
REQ-011 Port: dmem_ready  in  1  data-memory read data valid this cycle.
REQ-012 Port: dmem_rdata  in  8  data-memory read data.
REQ-013 Port: rf_we / rf_waddr / rf_wdata  out  1/5/8  register-file write port.
REQ-014 Port: wb_done  out  1  one-cycle pulse: instruction retired.
REQ-015 Port: last_result  out  8  last value written to the register file.
REQ-016 Port: mem_error  out  1  sticky load-timeout flag.

Function
REQ-017 FSM states: IDLE, MEM_WAIT, WRITE, DONE; reset state IDLE.
REQ-018 IDLE: accept only when current_state==4; ignore all other inputs.
REQ-019 Accepted with operation_code==6'b100011 (LW) and valid=1: latch dest_reg, dmem_addr<=execution_result, dmem_req<=1, go MEM_WAIT.
REQ-020 Accepted with valid=1 and any other opcode: latch dest_reg and execution_result, go WRITE.
REQ-021 Accepted with valid=0 (branches, unknown opcodes): go DONE; no memory or register-file activity.
REQ-022 MEM_WAIT: on the first cycle dmem_ready=1, latch dmem_rdata, drop dmem_req, go WRITE; dmem_ready in any other state is ignored.
REQ-023 WRITE: rf_we=1 for exactly one cycle with latched index/data; last_result updates the same edge; go DONE.
REQ-024 Index 0: rf_we stays 0 and last_result unchanged; all other timing identical.
REQ-025 DONE: wb_done=1 for exactly one cycle; return to IDLE.
REQ-026 Latency from accept: non-load 2 cycles to wb_done; load 2 cycles plus memory wait.
REQ-027 Inputs are sampled only at accept; changes while busy have no effect.
REQ-028 current_state leaving 4 mid-operation does not abort the operation.

Reset
REQ-029 rst_n low: immediately force IDLE; dmem_req, rf_we, wb_done, mem_error = 0; dmem_addr, rf_waddr, rf_wdata, last_result = 0.
REQ-030 Reset during MEM_WAIT abandons the load with no register-file write.
REQ-031 Reset deassertion is synchronized internally; first accept is possible on the second edge after release.

Configuration
REQ-032 Macro WB_TIMEOUT_EN defined: 8-bit counter runs in MEM_WAIT; when MEM_TIMEOUT cycles pass with no dmem_ready, drop dmem_req, set mem_error, skip WRITE, go DONE.
REQ-033 WB_TIMEOUT_EN defined: mem_error clears only on reset.
REQ-034 WB_TIMEOUT_EN not defined: no counter; MEM_WAIT waits indefinitely; mem_error is constant 0; MEM_TIMEOUT is unused.

Verification
REQ-035 ADDIU, result 8'h2A, dest 3 -> rf_we one cycle, waddr 3, wdata 2A, last_result 2A, wb_done 2 cycles after accept.
REQ-036 LW at address 8'h10, dmem_ready 3 cycles later with rdata 8'h55, dest 7 -> dmem_addr 10, req high 3 cycles, rf write 55 to reg 7.
REQ-037 BEQ, valid=0 -> no dmem_req, no rf_we, wb_done 1 cycle after accept.
REQ-038 ADDU to dest 0, result 8'hFF -> rf_we stays 0, last_result unchanged, wb_done asserted.
REQ-039 WB_TIMEOUT_EN defined, MEM_TIMEOUT=4, LW with no dmem_ready -> req drops after 4 cycles, mem_error=1, no rf_we, wb_done pulses.
REQ-040 rst_n low during MEM_WAIT -> dmem_req drops immediately, no rf_we, FSM IDLE, next ADDIU completes normally.
